ws2811_rx: RTL and testbench

// - Receiver/decoder for the WS2811 single-wire 800 kHz LED protocol. Measures the high time of each
//   bit on DI, rebuilds 24-bit GRB pixels, and reports the pixel index. Detects the low-gap latch.
// - Used as a loopback checker on the strip output and as a front end when the board acts as a slave.

---
 rtl/ws2811_pkg.sv | 49 ++++
 rtl/ws2811_rx_sync.sv | 52 +++++
 rtl/ws2811_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_ws2811_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2811_pkg.sv
// ws2811_pkg: shared definitions for the WS2811 transmitter and receiver.
//   - log2: ceiling log2 used to size address/counter fields (minimum 1).
//   - Timing helpers, all derived from the system clock frequency:
//       cycle_count  clocks per 1.25 us bit period
//       bit_thresh   high-time boundary between a '0' and a '1'
//       min_high     shortest high time accepted as a bit
//       max_high     longest high time accepted as a bit
//       latch_cycles low time that ends a frame (50 us)
//   - GRB color indices, in the order bytes appear on the wire.
package ws2811_pkg;

  localparam int COLOR_G = 0;
  localparam int COLOR_R = 1;
  localparam int COLOR_B = 2;

  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int cycle_count(input int sys_clk);
    return sys_clk / 800000;
  endfunction

  function automatic int bit_thresh(input int sys_clk);
    return cycle_count(sys_clk) * 3 / 8;
  endfunction

  function automatic int min_high(input int sys_clk);
    return cycle_count(sys_clk) / 8;
  endfunction

  function automatic int max_high(input int sys_clk);
    return cycle_count(sys_clk);
  endfunction

  function automatic int latch_cycles(input int sys_clk);
    return 40 * cycle_count(sys_clk);
  endfunction

  // LSB of a color byte inside the 24-bit word; G was shifted in first so it
  // ends up in the top byte.
  function automatic int color_lsb(input int color);
    return (2 - color) * 8;
  endfunction

endpackage

// File: rtl/ws2811_rx_sync.sv
// ws2811_rx_sync: brings the asynchronous DI line into the clk domain and
// produces single-cycle edge pulses.
//   clk, reset : clock, synchronous active-high reset
//   di         : raw serial input
//   level      : synchronized line level, aligned with rise/fall
//   rise, fall : 1-cycle pulses on the synchronized edges
// Two flops resolve metastability; the third delays the level so the edge
// pulses and level change in the same cycle (3 cycles from DI to edge).
module ws2811_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic di,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = di;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ws2811_rx.sv
// ws2811_rx: WS2811 800 kHz single-wire receiver.
//   clk, reset   : clock, synchronous active-high reset
//   DI           : asynchronous serial line
//   pixel_valid  : 1-cycle pulse, address/red/green/blue valid
//   address      : index of the presented pixel within the frame
//   red/green/blue : decoded bytes, held until the next pixel
//   frame_done   : 1-cycle pulse at the latch gap of a frame with data
//   pixel_count  : pixels in the finished frame (saturates at NUM_PIXELS)
//   error        : 1-cycle pulse on a bad pulse width, overflow pixel or
//                  partial pixel at latch
//   busy         : high from the first edge of a frame until its latch
// Each bit is classified by its high time, measured on the synchronized line.
module ws2811_rx
  import ws2811_pkg::*;
#(
  parameter int NUM_PIXELS   = 150,
  parameter int SYSTEM_CLOCK = 50000000,
  localparam int ADDR_W      = log2(NUM_PIXELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DI,
  output logic              pixel_valid,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              frame_done,
  output logic [ADDR_W:0]   pixel_count,
  output logic              error,
  output logic              busy
);

  localparam int HW = log2(max_high(SYSTEM_CLOCK) + 2);
  localparam int LW = log2(latch_cycles(SYSTEM_CLOCK) + 1);

  localparam logic [HW-1:0]   MIN_HIGH_C   = HW'(min_high(SYSTEM_CLOCK));
  localparam logic [HW-1:0]   MAX_HIGH_C   = HW'(max_high(SYSTEM_CLOCK));
  localparam logic [HW-1:0]   HIGH_SAT_C   = HW'(max_high(SYSTEM_CLOCK) + 1);
  localparam logic [HW-1:0]   BIT_THRESH_C = HW'(bit_thresh(SYSTEM_CLOCK));
  localparam logic [LW-1:0]   LATCH_C      = LW'(latch_cycles(SYSTEM_CLOCK));
  localparam logic [ADDR_W:0] NUM_PIX_C    = (ADDR_W + 1)'(NUM_PIXELS);

  localparam int G_LSB = color_lsb(COLOR_G);
  localparam int R_LSB = color_lsb(COLOR_R);
  localparam int B_LSB = color_lsb(COLOR_B);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  logic level, rise, fall;

  ws2811_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .di    (DI),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  state_t            state_q, state_d;
  logic [HW-1:0]     high_cnt_q, high_cnt_d;
  logic [LW-1:0]     low_cnt_q, low_cnt_d;
  logic [22:0]       shift_q, shift_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W:0]   pix_cnt_q, pix_cnt_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [7:0]        red_q, red_d;
  logic [7:0]        green_q, green_d;
  logic [7:0]        blue_q, blue_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W:0]   pixel_count_q, pixel_count_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;

  logic        bit_val;
  logic        pulse_ok;
  logic [23:0] word;

  always_comb begin
    bit_val  = (high_cnt_q >= BIT_THRESH_C);
    pulse_ok = (high_cnt_q >= MIN_HIGH_C) && (high_cnt_q <= MAX_HIGH_C);
    word     = {shift_q, bit_val};

    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    pixel_valid_d = 1'b0;
    address_d     = address_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    frame_done_d  = 1'b0;
    pixel_count_d = pixel_count_q;
    error_d       = 1'b0;
    busy_d        = busy_q;

    // high_cnt holds its value through the low phase so the falling edge
    // can classify it; low_cnt clears whenever the line is high, which also
    // restarts the SYNC wait on any pulse.
    if (rise)
      high_cnt_d = HW'(1);
    else if (level && high_cnt_q != HIGH_SAT_C)
      high_cnt_d = high_cnt_q + 1'b1;

    if (level)
      low_cnt_d = '0;
    else if (low_cnt_q != LATCH_C)
      low_cnt_d = low_cnt_q + 1'b1;

    if (pixel_valid_q)
      address_d = address_q + 1'b1;

    case (state_q)
      S_SYNC: begin
        if (low_cnt_q == LATCH_C)
          state_d = S_IDLE;
      end
      S_IDLE: begin
        if (rise) begin
          state_d   = S_HIGH;
          busy_d    = 1'b1;
          address_d = '0;
          pix_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      S_HIGH: begin
        if (fall) begin
          state_d = S_LOW;
          if (!pulse_ok) begin
            error_d   = 1'b1;
            bit_cnt_d = '0;
          end else begin
            shift_d = word[22:0];
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              if (pix_cnt_q < NUM_PIX_C) begin
                pixel_valid_d = 1'b1;
                address_d     = pix_cnt_q[ADDR_W-1:0];
                green_d       = word[G_LSB +: 8];
                red_d         = word[R_LSB +: 8];
                blue_d        = word[B_LSB +: 8];
                pix_cnt_d     = pix_cnt_q + 1'b1;
              end else begin
                // overflow pixels are counted as errors; pix_cnt stays
                // saturated at NUM_PIXELS
                error_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
        end else if (low_cnt_q == LATCH_C) begin
          state_d   = S_IDLE;
          error_d   = (bit_cnt_q != 5'd0);
          if (pix_cnt_q != '0) begin
            frame_done_d  = 1'b1;
            pixel_count_d = pix_cnt_q;
          end
          busy_d    = 1'b0;
          address_d = '0;
          bit_cnt_d = '0;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SYNC;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      pix_cnt_q     <= '0;
      pixel_valid_q <= 1'b0;
      address_q     <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_done_q  <= 1'b0;
      pixel_count_q <= '0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      pixel_valid_q <= pixel_valid_d;
      address_q     <= address_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      frame_done_q  <= frame_done_d;
      pixel_count_q <= pixel_count_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign address     = address_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_done  = frame_done_q;
  assign pixel_count = pixel_count_q;
  assign error       = error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ws2811_rx.sv
// tb_ws2811_rx: drives WS2811 symbol streams into ws2811_rx and checks the
// decoded pixels, frame_done counts and error pulses against a reference
// model that works on whole frames of symbols. A small NUM_PIXELS keeps the
// overflow cases short.
module tb_ws2811_rx;

  localparam int NP   = 4;
  localparam int AW   = 2;
  localparam int SYS  = 50000000;
  localparam int BITP = 62;
  localparam int T0H  = 19;
  localparam int T1H  = 39;
  localparam int GLH  = 4;
  localparam int GAP  = 2500;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          DI = 1'b0;
  logic          pixel_valid;
  logic [AW-1:0] address;
  logic [7:0]    red, green, blue;
  logic          frame_done;
  logic [AW:0]   pixel_count;
  logic          error;
  logic          busy;

  ws2811_rx #(.NUM_PIXELS(NP), .SYSTEM_CLOCK(SYS)) dut (
    .clk         (clk),
    .reset       (reset),
    .DI          (DI),
    .pixel_valid (pixel_valid),
    .address     (address),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_done  (frame_done),
    .pixel_count (pixel_count),
    .error       (error),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         addr;
    logic [7:0] g, r, b;
  } pix_t;

  typedef struct {
    int cnt;
    bit with_err;
  } fd_t;

  pix_t exp_pix[$];
  fd_t  exp_fd[$];
  int   sym[$];          // 0 / 1 = data bit, 2 = short glitch pulse
  int   checks = 0;
  int   failures = 0;
  int   err_seen = 0;
  int   exp_err = 0;
  pix_t mon_p;
  fd_t  mon_f;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents something.
  always @(negedge clk) begin
    if (!reset) begin
      if (error) err_seen++;
      if (pixel_valid) begin
        check("pixel_valid_with_error", error, 0);
        if (exp_pix.size() == 0) begin
          check("unexpected_pixel_valid", 1, 0);
        end else begin
          mon_p = exp_pix.pop_front();
          check("pixel_address", address, mon_p.addr);
          check("pixel_green", green, mon_p.g);
          check("pixel_red", red, mon_p.r);
          check("pixel_blue", blue, mon_p.b);
        end
      end
      if (frame_done) begin
        if (exp_fd.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          mon_f = exp_fd.pop_front();
          check("frame_pixel_count", pixel_count, mon_f.cnt);
          check("frame_done_error", error, mon_f.with_err);
        end
      end
    end
  end

  // Reference model: a frame is a list of symbols; every 24 good bits form a
  // GRB pixel, a glitch throws away the bits collected so far.
  task automatic model_frame();
    logic [23:0] acc;
    int nb;
    int k;
    acc = '0;
    nb  = 0;
    k   = 0;
    foreach (sym[i]) begin
      if (sym[i] == 2) begin
        exp_err++;
        nb = 0;
      end else begin
        acc = {acc[22:0], (sym[i] == 1)};
        nb++;
        if (nb == 24) begin
          nb = 0;
          if (k < NP) exp_pix.push_back('{k, acc[23:16], acc[15:8], acc[7:0]});
          else        exp_err++;
          k++;
        end
      end
    end
    if (nb != 0) exp_err++;
    if (k > 0) exp_fd.push_back('{(k < NP) ? k : NP, (nb != 0)});
  endtask

  task automatic drive_sym(input int s);
    int h;
    h = (s == 2) ? GLH : ((s == 1) ? T1H : T0H);
    DI = 1'b1;
    repeat (h) @(negedge clk);
    DI = 1'b0;
    repeat (BITP - h) @(negedge clk);
  endtask

  task automatic gap(input int n);
    DI = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) sym.push_back(int'(v[i]));
  endtask

  task automatic push_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    push_byte(g);
    push_byte(r);
    push_byte(b);
  endtask

  task automatic push_rand_bits(input int n);
    for (int i = 0; i < n; i++) sym.push_back(int'($urandom_range(0, 1)));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_pix.size() != 0 || exp_fd.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_pixels_left"}, exp_pix.size(), 0);
    check({name, "_frames_left"}, exp_fd.size(), 0);
    check({name, "_error_total"}, err_seen, exp_err);
  endtask

  task automatic run_frame(input string name);
    model_frame();
    foreach (sym[i]) begin
      drive_sym(sym[i]);
      if (i == 0) check({name, "_busy_in_frame"}, busy, 1);
    end
    sym.delete();
    gap(GAP);
    check({name, "_busy_after_latch"}, busy, 0);
    wait_drain(name);
  endtask

  initial begin
    int np;
    int extra;

    // reset state
    reset = 1'b1;
    DI    = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_address", address, 0);
    check("rst_red", red, 0);
    check("rst_green", green, 0);
    check("rst_blue", blue, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pixel_count", pixel_count, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    gap(GAP);

    push_pixel(8'hA5, 8'h3C, 8'hFF);
    run_frame("one_pixel");

    for (int i = 0; i < NP; i++) push_pixel(8'(i), ~8'(i), 8'(i) ^ 8'h55);
    run_frame("full_frame");

    for (int i = 0; i < NP + 2; i++) push_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    run_frame("overflow");

    push_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    push_rand_bits(10);
    run_frame("partial_latch");

    push_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    push_rand_bits(10);
    sym.push_back(2);
    push_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    run_frame("glitch");

    // reset mid-pixel, then data with no preceding latch gap: nothing may be
    // decoded or flagged until a full gap has been seen
    push_rand_bits(12);
    foreach (sym[i]) drive_sym(sym[i]);
    sym.delete();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("mid_reset_busy", busy, 0);
    repeat (20) @(negedge clk);
    push_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    foreach (sym[i]) drive_sym(sym[i]);
    sym.delete();
    gap(GAP);
    wait_drain("sync_after_reset");
    push_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    run_frame("after_reset");

    for (int f = 0; f < 2; f++) begin
      np    = $urandom_range(1, 2);
      extra = $urandom_range(0, 3);
      for (int i = 0; i < np; i++) push_pixel(8'($urandom), 8'($urandom), 8'($urandom));
      push_rand_bits(extra);
      run_frame($sformatf("random_%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
